// File: rtl/ram_ctrl.sv
// ram_ctrl: burst controller in front of a negedge-sampled single-port RAM.
// Requests start write or read bursts of 1..16 words. Write data arrives on a
// per-beat handshake. Read data comes back one cycle after each read is issued.
// Optional feature macro: RAM_CTRL_READBACK_EN adds a read-back check of every
// written word and the sticky err/err_addr outputs.
module ram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  input  logic [DATA_WIDTH-1:0] ram_data_out
`ifdef RAM_CTRL_READBACK_EN
  ,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_live;
  logic [ADDR_WIDTH-1:0] r_curAddr;
  logic [3:0]            r_beatCnt;
  logic                  r_ramCs;
  logic                  r_ramWe;
  logic                  r_ramOe;
  logic [ADDR_WIDTH-1:0] r_ramAddress;
  logic [DATA_WIDTH-1:0] r_ramDataIn;
  logic                  r_issueRead;
  logic                  r_issueLast;
  logic                  r_rdValid;
  logic                  r_rdLast;
  logic [DATA_WIDTH-1:0] r_rdData;

  state_t                w_nextState;
  logic [ADDR_WIDTH-1:0] w_nextCurAddr;
  logic [3:0]            w_nextCnt;
  logic                  w_nextCs;
  logic                  w_nextWe;
  logic                  w_nextOe;
  logic [ADDR_WIDTH-1:0] w_nextRamAddr;
  logic [DATA_WIDTH-1:0] w_nextRamData;
  logic                  w_nextIssueRead;
  logic                  w_nextIssueLast;
  logic                  w_reqFire;

`ifdef RAM_CTRL_READBACK_EN
  logic                  r_rbPending;
  logic                  r_rbCheck;
  logic [ADDR_WIDTH-1:0] r_rbAddr;
  logic [DATA_WIDTH-1:0] r_rbData;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_errAddr;
  logic                  w_nextRbPending;
  logic                  w_nextRbCheck;
  logic [ADDR_WIDTH-1:0] w_nextRbAddr;
  logic [DATA_WIDTH-1:0] w_nextRbData;

  // Write data is refused while the read-back of the previous word is issued.
  assign wr_ready = (r_state == WRITE) && !r_rbPending;
  assign err      = r_err;
  assign err_addr = r_errAddr;
`else
  assign wr_ready = (r_state == WRITE);
`endif

  // r_live keeps req_ready low until the first edge after reset is released.
  assign req_ready   = (r_state == IDLE) && r_live;
  assign busy        = (r_state != IDLE);
  assign w_reqFire   = req_valid && req_ready;
  assign ram_cs      = r_ramCs;
  assign ram_we      = r_ramWe;
  assign ram_oe      = r_ramOe;
  assign ram_address = r_ramAddress;
  assign ram_data_in = r_ramDataIn;
  assign rd_valid    = r_rdValid;
  assign rd_last     = r_rdLast;
  assign rd_data     = r_rdData;

  // Next-state and next RAM command; r_beatCnt always holds beats left minus one.
  always_comb begin
    w_nextState     = r_state;
    w_nextCurAddr   = r_curAddr;
    w_nextCnt       = r_beatCnt;
    w_nextCs        = 1'b0;
    w_nextWe        = 1'b0;
    w_nextOe        = 1'b0;
    w_nextRamAddr   = r_ramAddress;
    w_nextRamData   = r_ramDataIn;
    w_nextIssueRead = 1'b0;
    w_nextIssueLast = 1'b0;
`ifdef RAM_CTRL_READBACK_EN
    w_nextRbPending = r_rbPending;
    w_nextRbCheck   = 1'b0;
    w_nextRbAddr    = r_rbAddr;
    w_nextRbData    = r_rbData;
`endif
    case (r_state)
      IDLE: begin
        if (w_reqFire) begin
          if (req_write) begin
            w_nextState   = WRITE;
            w_nextCurAddr = req_addr;
            w_nextCnt     = req_len;
          end else begin
            w_nextCs        = 1'b1;
            w_nextOe        = 1'b1;
            w_nextRamAddr   = req_addr;
            w_nextIssueRead = 1'b1;
            w_nextIssueLast = (req_len == 4'd0);
            w_nextCurAddr   = req_addr + ADDR_WIDTH'(1);
            w_nextCnt       = req_len - 4'd1;
            w_nextState     = (req_len == 4'd0) ? IDLE : READ;
          end
        end
      end
      WRITE: begin
`ifdef RAM_CTRL_READBACK_EN
        if (r_rbPending) begin
          w_nextCs        = 1'b1;
          w_nextOe        = 1'b1;
          w_nextRamAddr   = r_rbAddr;
          w_nextRbCheck   = 1'b1;
          w_nextRbPending = 1'b0;
          if (r_beatCnt == 4'd0) begin
            w_nextState = IDLE;
          end else begin
            w_nextCnt = r_beatCnt - 4'd1;
          end
        end else if (wr_valid) begin
          w_nextCs        = 1'b1;
          w_nextWe        = 1'b1;
          w_nextRamAddr   = r_curAddr;
          w_nextRamData   = wr_data;
          w_nextCurAddr   = r_curAddr + ADDR_WIDTH'(1);
          w_nextRbPending = 1'b1;
          w_nextRbAddr    = r_curAddr;
          w_nextRbData    = wr_data;
        end
`else
        if (wr_valid) begin
          w_nextCs      = 1'b1;
          w_nextWe      = 1'b1;
          w_nextRamAddr = r_curAddr;
          w_nextRamData = wr_data;
          w_nextCurAddr = r_curAddr + ADDR_WIDTH'(1);
          if (r_beatCnt == 4'd0) begin
            w_nextState = IDLE;
          end else begin
            w_nextCnt = r_beatCnt - 4'd1;
          end
        end
`endif
      end
      READ: begin
        w_nextCs        = 1'b1;
        w_nextOe        = 1'b1;
        w_nextRamAddr   = r_curAddr;
        w_nextIssueRead = 1'b1;
        w_nextIssueLast = (r_beatCnt == 4'd0);
        w_nextCurAddr   = r_curAddr + ADDR_WIDTH'(1);
        if (r_beatCnt == 4'd0) begin
          w_nextState = IDLE;
        end else begin
          w_nextCnt = r_beatCnt - 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_live  <= 1'b1;
    end
  end

  // RAM command registers, stable by the negedge at which the RAM samples them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curAddr    <= '0;
      r_beatCnt    <= '0;
      r_ramCs      <= 1'b0;
      r_ramWe      <= 1'b0;
      r_ramOe      <= 1'b0;
      r_ramAddress <= '0;
      r_ramDataIn  <= '0;
      r_issueRead  <= 1'b0;
      r_issueLast  <= 1'b0;
    end else begin
      r_curAddr    <= w_nextCurAddr;
      r_beatCnt    <= w_nextCnt;
      r_ramCs      <= w_nextCs;
      r_ramWe      <= w_nextWe;
      r_ramOe      <= w_nextOe;
      r_ramAddress <= w_nextRamAddr;
      r_ramDataIn  <= w_nextRamData;
      r_issueRead  <= w_nextIssueRead;
      r_issueLast  <= w_nextIssueLast;
    end
  end

  // Capture read data one cycle after the read was issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdValid <= 1'b0;
      r_rdLast  <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= r_issueRead;
      r_rdLast  <= r_issueRead && r_issueLast;
      if (r_issueRead) begin
        r_rdData <= ram_data_out;
      end
    end
  end

`ifdef RAM_CTRL_READBACK_EN
  // Read-back bookkeeping and sticky error capture against the held write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rbPending <= 1'b0;
      r_rbCheck   <= 1'b0;
      r_rbAddr    <= '0;
      r_rbData    <= '0;
      r_err       <= 1'b0;
      r_errAddr   <= '0;
    end else begin
      r_rbPending <= w_nextRbPending;
      r_rbCheck   <= w_nextRbCheck;
      r_rbAddr    <= w_nextRbAddr;
      r_rbData    <= w_nextRbData;
      if (r_rbCheck && (ram_data_out != r_rbData) && !r_err) begin
        r_err     <= 1'b1;
        r_errAddr <= r_rbAddr;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed self-checking bench for ram_ctrl with a negedge RAM model.
// Define RAM_CTRL_READBACK_EN on both bench and design to exercise the read-back check.
module tb_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic [7:0]  ram_address;
  logic [15:0] ram_data_in;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [15:0] ram_data_out;
`ifdef RAM_CTRL_READBACK_EN
  logic        err;
  logic [7:0]  err_addr;
`endif

  logic [15:0] mem [0:255];
  int          checkCount;
  int          passCount;

  ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_oe       (ram_oe),
    .ram_data_out (ram_data_out)
`ifdef RAM_CTRL_READBACK_EN
    ,
    .err          (err),
    .err_addr     (err_addr)
`endif
  );

  // 10 ns clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM sampling its controls on the falling edge.
  always @(negedge clk) begin
    if (ram_cs && ram_we) begin
      mem[ram_address] <= ram_data_in;
    end
    if (ram_cs && ram_oe) begin
`ifdef RAM_CTRL_READBACK_EN
      if (ram_address == 8'h22) begin
        ram_data_out <= mem[ram_address] & 16'hFFFE;
      end else begin
        ram_data_out <= mem[ram_address];
      end
`else
      ram_data_out <= mem[ram_address];
`endif
    end
  end

  // Reset values while held, then req_ready rising at the first edge after release.
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checkCount++;
    if ({req_ready, wr_ready, rd_valid, rd_last, busy, ram_cs, ram_we, ram_oe} !== 8'h00)
      $display("[TB] FAIL reset_flags got=%b want=00000000",
               {req_ready, wr_ready, rd_valid, rd_last, busy, ram_cs, ram_we, ram_oe});
    else passCount++;
    checkCount++;
    if ({ram_address, ram_data_in, rd_data} !== 40'h0)
      $display("[TB] FAIL reset_data got=%h want=0", {ram_address, ram_data_in, rd_data});
    else passCount++;
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (req_ready !== 1'b0) $display("[TB] FAIL ready_before_edge got=%b want=0", req_ready);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if (req_ready !== 1'b1) $display("[TB] FAIL ready_after_edge got=%b want=1", req_ready);
    else passCount++;
  endtask

  // Write burst; gapAt >= 0 drops wr_valid for two cycles before that beat.
  task automatic doWriteBurst(input logic [7:0] addr, input logic [3:0] len,
                              input logic [15:0] base, input int gapAt);
    logic [7:0]  expAddr;
    logic [15:0] expData;
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_len = len;
    checkCount++;
    if (req_ready !== 1'b1) $display("[TB] FAIL wr_req_ready got=%b want=1", req_ready);
    else passCount++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkCount++;
    if ({busy, wr_ready, ram_cs} !== 3'b110)
      $display("[TB] FAIL wr_accept got=%b want=110", {busy, wr_ready, ram_cs});
    else passCount++;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == gapAt) begin
        wr_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          @(posedge clk); #1;
          checkCount++;
          if (ram_cs !== 1'b0) $display("[TB] FAIL wr_gap_cs got=%b want=0", ram_cs);
          else passCount++;
        end
      end
      expAddr = addr + 8'(i);
      expData = base + 16'(i);
      wr_valid = 1'b1; wr_data = expData;
      @(posedge clk); #1;
      checkCount++;
      if ({ram_cs, ram_we, ram_oe, ram_address, ram_data_in} !== {3'b110, expAddr, expData})
        $display("[TB] FAIL wr_beat%0d got=%b/%h/%h want=110/%h/%h", i,
                 {ram_cs, ram_we, ram_oe}, ram_address, ram_data_in, expAddr, expData);
      else passCount++;
    end
    wr_valid = 1'b0;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL wr_done_busy got=%b want=0", busy);
    else passCount++;
  endtask

  // Read burst expecting base, base+1, ... on consecutive cycles after acceptance.
  task automatic doReadBurst(input logic [7:0] addr, input logic [3:0] len,
                             input logic [15:0] base);
    logic [15:0] expData;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_len = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkCount++;
    if ({ram_cs, ram_we, ram_oe, ram_address} !== {3'b101, addr})
      $display("[TB] FAIL rd_first_issue got=%b/%h want=101/%h",
               {ram_cs, ram_we, ram_oe}, ram_address, addr);
    else passCount++;
    for (int i = 0; i <= int'(len); i++) begin
      @(posedge clk); #1;
      expData = base + 16'(i);
      checkCount++;
      if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == int'(len)), expData})
        $display("[TB] FAIL rd_beat%0d got=%b%b/%h want=1%b/%h", i,
                 rd_valid, rd_last, rd_data, (i == int'(len)), expData);
      else passCount++;
    end
    @(posedge clk); #1;
    checkCount++;
    if ({rd_valid, rd_last, busy, ram_cs} !== 4'b0000)
      $display("[TB] FAIL rd_after got=%b want=0000", {rd_valid, rd_last, busy, ram_cs});
    else passCount++;
  endtask

  task automatic test_write_read();
    doWriteBurst(8'h10, 4'd3, 16'hA000, -1);
    doReadBurst(8'h10, 4'd3, 16'hA000);
  endtask

  task automatic test_wrap();
    doWriteBurst(8'hFE, 4'd3, 16'hB000, -1);
    doReadBurst(8'hFE, 4'd3, 16'hB000);
  endtask

  task automatic test_write_gap();
    doWriteBurst(8'h40, 4'd3, 16'hC000, 2);
    doReadBurst(8'h40, 4'd3, 16'hC000);
  endtask

  task automatic test_len0();
    doReadBurst(8'h12, 4'd0, 16'hA002);
  endtask

  // Last read beat of one burst coincides with acceptance of the next request.
  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 4'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkCount++;
    if ({rd_valid, rd_last, rd_data, req_ready} !== {2'b10, 16'hA000, 1'b1})
      $display("[TB] FAIL b2b_beat0 got=%b%b/%h/%b want=10/a000/1",
               rd_valid, rd_last, rd_data, req_ready);
    else passCount++;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'hFE; req_len = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkCount++;
    if ({rd_valid, rd_last, rd_data, ram_oe, ram_address} !== {2'b11, 16'hA001, 1'b1, 8'hFE})
      $display("[TB] FAIL b2b_overlap got=%b%b/%h/%b/%h want=11/a001/1/fe",
               rd_valid, rd_last, rd_data, ram_oe, ram_address);
    else passCount++;
    @(posedge clk); #1;
    checkCount++;
    if ({rd_valid, rd_last, rd_data} !== {2'b11, 16'hB000})
      $display("[TB] FAIL b2b_second got=%b%b/%h want=11/b000", rd_valid, rd_last, rd_data);
    else passCount++;
  endtask

  // Reset during beat 2 of an 8-beat read, then a clean burst after release.
  task automatic test_reset_midburst();
    int badCount;
    badCount = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_len = 4'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({rd_valid, rd_last, busy, req_ready, wr_ready, ram_cs, ram_we, ram_oe,
         ram_address, ram_data_in, rd_data} !== 48'h0)
      $display("[TB] FAIL midreset_outputs got=%b/%h/%h/%h want=0/0/0/0",
               {rd_valid, rd_last, busy, req_ready, wr_ready, ram_cs, ram_we, ram_oe},
               ram_address, ram_data_in, rd_data);
    else passCount++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (rd_last !== 1'b0 || ram_cs !== 1'b0 || rd_valid !== 1'b0) badCount++;
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    if (rd_last !== 1'b0 || ram_cs !== 1'b0) badCount++;
    checkCount++;
    if (badCount != 0) $display("[TB] FAIL midreset_quiet got=%0d want=0", badCount);
    else passCount++;
    doReadBurst(8'h10, 4'd3, 16'hA000);
  endtask

`ifdef RAM_CTRL_READBACK_EN
  // Stuck-at-0 bit 0 at 0x22 must raise a sticky error naming that address.
  task automatic test_readback();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h22; req_len = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr_valid = 1'b1; wr_data = 16'h0001;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    checkCount++;
    if (wr_ready !== 1'b0) $display("[TB] FAIL rb_wr_ready got=%b want=0", wr_ready);
    else passCount++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkCount++;
    if ({err, err_addr} !== {1'b1, 8'h22})
      $display("[TB] FAIL rb_err got=%b/%h want=1/22", err, err_addr);
    else passCount++;
    repeat (4) @(posedge clk);
    #1;
    checkCount++;
    if ({err, err_addr} !== {1'b1, 8'h22})
      $display("[TB] FAIL rb_err_held got=%b/%h want=1/22", err, err_addr);
    else passCount++;
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
    ram_data_out = 16'h0000;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 4'd0;
    wr_valid = 1'b0; wr_data = 16'h0000;
    checkCount = 0;
    passCount = 0;
    test_reset();
`ifdef RAM_CTRL_READBACK_EN
    test_readback();
`else
    test_write_read();
    test_wrap();
    test_write_gap();
    test_len0();
    test_back_to_back();
    test_reset_midburst();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the RAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SHALL set the RAM address width.
REQ-003 clk  in  1  SHALL be the single clock; all registers update on posedge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  SHALL form the request handshake; transfer occurs on a posedge with both high.
REQ-006 req_write  in  1  SHALL select the operation: 1 = write burst, 0 = read burst.
REQ-007 req_addr  in  ADDR_WIDTH  SHALL give the burst start address.
REQ-008 req_len  in  4  SHALL give the burst length minus one (1..16 words).
REQ-009 wr_valid/wr_ready  in/out  1/1 and wr_data  in  DATA_WIDTH  SHALL form the per-beat write-data handshake.
REQ-010 rd_valid  out  1, rd_data  out  DATA_WIDTH, rd_last  out  1  SHALL return read beats with no backpressure.
REQ-011 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-012 ram_address  out  ADDR_WIDTH, ram_data_in  out  DATA_WIDTH, ram_cs/ram_we/ram_oe  out  1 each  SHALL drive the negedge-sampled single-port RAM.
REQ-013 ram_data_out  in  DATA_WIDTH  SHALL carry RAM read data, updated by the RAM on negedge when cs&&oe.

Function
REQ-014 All ram_* outputs SHALL be registered on posedge so they are stable at the following negedge, when the RAM samples them.
REQ-015 The FSM SHALL have states IDLE, WRITE, READ; req_ready = 1 only in IDLE.
REQ-016 IDLE: on request handshake, latch addr and len into cur_addr and beat counter; go to WRITE if req_write, else READ.
REQ-017 WRITE: wr_ready = 1; each wr handshake at posedge k SHALL register ram_cs=1, ram_we=1, ram_oe=0, ram_address=cur_addr, ram_data_in=wr_data for cycle k.
REQ-018 WRITE with wr_valid=0 SHALL register ram_cs=ram_we=0 (idle beat); the counter and address hold.
REQ-019 READ: the first read is issued at the accepting posedge A (ram_cs=1, ram_oe=1, ram_we=0, ram_address=req_addr); one read is issued per cycle after that, with no gaps.
REQ-020 A read issued at posedge k SHALL be captured from ram_data_out at posedge k+1, with rd_valid=1 for that cycle; read latency is 1 cycle.
REQ-021 rd_last SHALL be high with the final beat only.
REQ-022 cur_addr SHALL increment by 1 per issued beat, modulo 2^ADDR_WIDTH; address 255 wraps to 0.
REQ-023 After the last beat is issued, the FSM SHALL return to IDLE; the last read's rd_valid MAY coincide with a new request acceptance.
REQ-024 When no access is issued, ram_cs, ram_we and ram_oe SHALL be 0.
REQ-025 A request accepted with req_len=0 SHALL perform exactly one beat.

Reset
REQ-026 While rst_n=0: state=IDLE; req_ready, wr_ready, rd_valid, rd_last, busy, ram_cs, ram_we, ram_oe = 0; ram_address, ram_data_in, rd_data = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, with no further RAM accesses and no partial rd_last.
REQ-028 req_ready SHALL rise at the first posedge after rst_n deasserts.

Configuration
REQ-029 Macro RAM_CTRL_READBACK_EN, when defined, SHALL follow each write beat with a read of the same address in the next cycle (wr_ready=0 that cycle).
REQ-030 With RAM_CTRL_READBACK_EN, the capture one cycle later SHALL compare against the held write data; a mismatch SHALL set sticky output err=1 and err_addr to the failing address, cleared only by reset.
REQ-031 Without RAM_CTRL_READBACK_EN, err and err_addr ports SHALL be absent and writes SHALL sustain one beat per cycle.

Verification
REQ-032 Write burst addr=0x10, len=3, data 0xA000..0xA003 continuous, then read burst addr=0x10, len=3 -> rd_data 0xA000..0xA003 on 4 consecutive cycles starting 1 cycle after acceptance; rd_last on 0xA003.
REQ-033 Write addr=0xFE, len=3 -> RAM writes at 0xFE, 0xFF, 0x00, 0x01; readback of 0xFE, len=3 returns the same data in order.
REQ-034 Write burst with wr_valid dropped for 2 cycles mid-burst -> ram_cs=0 for those 2 cycles, and no address skipped.
REQ-035 Assert rst_n=0 during beat 2 of a len=7 read -> all outputs 0 asynchronously, and no rd_last; a new request after release works normally.
REQ-036 With RAM_CTRL_READBACK_EN and a bench RAM model forcing bit 0 stuck at 0 at address 0x22, write 0x0001 to 0x22 -> err=1, err_addr=0x22, held until reset.
